// File: rtl/output_arbiter.sv
// Round-robin output arbiter: grants one requester at a time into a shared 8-bit output register.
// Build option OUTARB_FIXED_PRIO_EN switches selection to fixed priority (requester 0 highest).
module output_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              out_load,
    output logic [7:0]        out_data,
    output logic [2:0]        out_owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [2:0] OWNER_RST = 3'(NREQ - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] out_data_nxt;
    logic [2:0] out_owner_nxt;
    logic [2:0] winner;
    logic [7:0] winner_data;

`ifdef OUTARB_FIXED_PRIO_EN
    // Lowest set index wins; the previous owner plays no part.
    function automatic logic [2:0] pick_winner(input logic [NREQ-1:0] r,
                                               input logic [2:0]      last);
        logic [2:0] win;
        win = last;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (r[j]) win = 3'(j);
        end
        return win;
    endfunction
`else
    // Search order is last+1, last+2, ... wrapping; walking offsets from the far end
    // lets the nearest set requester overwrite the others.
    function automatic logic [2:0] pick_winner(input logic [NREQ-1:0] r,
                                               input logic [2:0]      last);
        logic [2:0] win;
        win = last;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (r[j] && (j == ((int'(last) + k) % NREQ))) win = 3'(j);
            end
        end
        return win;
    endfunction
`endif

    function automatic logic [7:0] select_data(input logic [8*NREQ-1:0] d,
                                               input logic [2:0]        idx);
        logic [7:0] sel;
        sel = 8'h00;
        for (int j = 0; j < NREQ; j++) begin
            if (idx == 3'(j)) sel = d[8*j +: 8];
        end
        return sel;
    endfunction

    assign winner      = pick_winner(req, out_owner);
    assign winner_data = select_data(data, winner);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'h00;
            out_data  <= 8'h00;
            out_owner <= OWNER_RST;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_data  <= out_data_nxt;
            out_owner <= out_owner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_data_nxt  = out_data;
        out_owner_nxt = out_owner;
        case (state)
            S_IDLE: begin
                // Data is captured only here, so later changes cannot corrupt the grant.
                if (|req) begin
                    state_nxt     = S_GRANT;
                    out_owner_nxt = winner;
                    out_data_nxt  = winner_data;
                end
            end
            S_GRANT: begin
                state_nxt = S_HOLD;
                cnt_nxt   = HOLD_LOAD;
            end
            S_HOLD: begin
                if (cnt == 8'h00) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'h01;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'h00;
            end
        endcase
    end

    // Outputs decode straight from state, so an asynchronous reset kills any pulse at once.
    always_comb begin
        out_load = (state == S_GRANT);
        busy     = (state != S_IDLE);
        ack      = '0;
        for (int j = 0; j < NREQ; j++) begin
            ack[j] = out_load && (out_owner == 3'(j));
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter (NREQ=4, HOLD=4); expectations are hand-computed.
module tb_output_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic              out_load;
    logic [7:0]        out_data;
    logic [2:0]        out_owner;
    logic              busy;

    int total;
    int bad;

    output_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .out_load (out_load),
        .out_data (out_data),
        .out_owner(out_owner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_idx;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = '0;
        data  = '0;

        // Reset state
        tick();
        tick();
        check("rst_ack",   32'(ack),       32'h0);
        check("rst_load",  32'(out_load),  32'h0);
        check("rst_data",  32'(out_data),  32'h00);
        check("rst_owner", 32'(out_owner), 32'h3);
        check("rst_busy",  32'(busy),      32'h0);

        // Single request from requester 2
        reset = 1'b0;
        req   = 4'b0100;
        data[23:16] = 8'hA5;
        tick();
        check("g2_ack",   32'(ack),       32'h4);
        check("g2_load",  32'(out_load),  32'h1);
        check("g2_data",  32'(out_data),  32'hA5);
        check("g2_owner", 32'(out_owner), 32'h2);
        check("g2_busy",  32'(busy),      32'h1);
        req = '0;
        for (int k = 1; k <= HOLD; k++) begin
            tick();
            check("g2_hold_busy", 32'(busy),     32'h1);
            check("g2_hold_ack",  32'(ack),      32'h0);
            check("g2_hold_load", 32'(out_load), 32'h0);
        end
        tick();
        check("g2_idle_busy", 32'(busy), 32'h0);

        // Requester 1: data changes during GRANT; requester 0 pulses only during HOLD
        req = 4'b0010;
        data[15:8] = 8'h3C;
        tick();
        check("g1_ack",   32'(ack),       32'h2);
        check("g1_data",  32'(out_data),  32'h3C);
        check("g1_owner", 32'(out_owner), 32'h1);
        data[15:8] = 8'hFF;
        req = '0;
        tick();
        req = 4'b0001;
        data[7:0] = 8'h77;
        check("g1_hold_ack", 32'(ack), 32'h0);
        tick();
        req = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("pulse_ack",  32'(ack),      32'h0);
            check("pulse_load", 32'(out_load), 32'h0);
        end
        check("g1_data_kept",  32'(out_data),  32'h3C);
        check("g1_owner_kept", 32'(out_owner), 32'h1);

        // Continuous requests from all four after a fresh reset
        reset = 1'b1;
        #1;
        check("rst2_owner", 32'(out_owner), 32'h3);
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        data  = 32'h13121110;
        tick();
        check("rr0_ack",  32'(ack),      32'h1);
        check("rr0_data", 32'(out_data), 32'h10);
        for (int g = 1; g <= 4; g++) begin
            for (int k = 0; k < HOLD + 1; k++) begin
                tick();
                check("rr_gap_ack", 32'(ack), 32'h0);
            end
            tick();
`ifdef OUTARB_FIXED_PRIO_EN
            exp_idx = 2'd0;
`else
            exp_idx = 2'(g % NREQ);
`endif
            check("rr_ack",   32'(ack),       32'(4'b0001 << exp_idx));
            check("rr_owner", 32'(out_owner), 32'(exp_idx));
            check("rr_data",  32'(out_data),  32'(8'h10 + 8'(exp_idx)));
        end
        req = '0;
        for (int k = 0; k < HOLD + 1; k++) tick();
        check("rr_idle_busy", 32'(busy), 32'h0);

        // Reset in HOLD after a grant to requester 3
        req = 4'b1000;
        data[31:24] = 8'hC3;
        tick();
        check("g3_ack",   32'(ack),       32'h8);
        check("g3_owner", 32'(out_owner), 32'h3);
        check("g3_data",  32'(out_data),  32'hC3);
        req = '0;
        tick();
        check("g3_hold_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_ack",   32'(ack),       32'h0);
        check("abort_load",  32'(out_load),  32'h0);
        check("abort_data",  32'(out_data),  32'h00);
        check("abort_busy",  32'(busy),      32'h0);
        check("abort_owner", 32'(out_owner), 32'h3);
        tick();
        check("abort_rst_ack", 32'(ack), 32'h0);
        reset = 1'b0;
        req   = 4'b1001;
        data[7:0] = 8'h5A;
        tick();
        check("post_rst_ack",   32'(ack),       32'h1);
        check("post_rst_owner", 32'(out_owner), 32'h0);
        check("post_rst_data",  32'(out_data),  32'h5A);
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
